// File: rtl/cnn_fmap_reader_pkg.sv
// Shared types and sizes for the feature-map reader: map geometry, beat layout and FSM states.
// Pure declarations, so there is no latency or backpressure here.
package cnn_fmap_reader_pkg;
  localparam int DATA_W = 32;
  localparam int OUT_W  = 6;
  localparam int OUT_H  = 6;
  localparam int N_PIX  = OUT_W * OUT_H;
  localparam int ADDR_W = $clog2(N_PIX);
  localparam int IDX_W  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    STREAM = 2'd2,
    FINISH = 2'd3
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  row;
    logic [IDX_W-1:0]  col;
    logic              last;
  } beat_t;
endpackage

// File: rtl/cnn_fmap_reader_if.sv
// Output beat bus of the reader; master drives valid/payload, slave returns ready.
// Wires only: no latency; the payload must hold while valid is high and ready is low.
interface cnn_fmap_reader_if;
  import cnn_fmap_reader_pkg::*;

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [IDX_W-1:0]  m_row;
  logic [IDX_W-1:0]  m_col;
  logic              m_last;

  modport master (output m_valid, m_data, m_row, m_col, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_row, m_col, m_last, output m_ready);
endinterface

// File: rtl/cnn_fmap_reader_out_slice.sv
// Single-entry valid/ready register slice for one beat; load to valid is 1 clk.
// Holds its beat while ready is low; flush drops it without a handshake.
module fmap_out_slice
  import cnn_fmap_reader_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load_i,
  input  logic  flush_i,
  input  beat_t beat_i,
  input  logic  ready_i,
  output logic  valid_o,
  output beat_t beat_o
);
  logic  valid_q;
  beat_t beat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      beat_q  <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      beat_q  <= beat_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign beat_o  = beat_q;
endmodule

// File: rtl/cnn_fmap_reader.sv
// Streams the engine result map in raster order once eng_done rises; first beat 2 clk after the edge.
// One beat per 2 clk under full ready; stalls hold the beat, and eng_done falling aborts the stream.
module cnn_fmap_reader
  import cnn_fmap_reader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] fmap_ram_i [0:N_PIX-1],
  input  logic              eng_done_i,
  output logic              busy_o,
  output logic              drained_o,
  output logic              aborted_o,
  cnn_fmap_reader_if.master m_if
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);
  localparam logic [IDX_W-1:0]  LAST_COL  = IDX_W'(OUT_W - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [IDX_W-1:0]  row_q;
  logic [IDX_W-1:0]  col_q;
  logic              done_q;
  logic              busy_q;
  logic              drained_q;
  logic              aborted_q;

  logic  done_rise;
  logic  done_fall;
  logic  out_vld;
  logic  xfer;
  logic  load;
  beat_t beat_in;
  beat_t beat_out;

  assign done_rise = eng_done_i && !done_q;
  // A fall only matters mid-stream; outside busy the engine is free to drop done.
  assign done_fall = !eng_done_i && done_q && busy_q;
  assign xfer      = out_vld && m_if.m_ready;
  assign load      = (state_q == READ) && !done_fall;

  always_comb begin
    beat_in      = '0;
    beat_in.data = fmap_ram_i[addr_q];
    beat_in.row  = row_q;
    beat_in.col  = col_q;
    beat_in.last = (addr_q == LAST_ADDR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      drained_q <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      done_q    <= eng_done_i;
      drained_q <= 1'b0;
      aborted_q <= 1'b0;
      if (done_fall) begin
        state_q   <= IDLE;
        busy_q    <= 1'b0;
        aborted_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (done_rise) begin
              state_q <= READ;
              addr_q  <= '0;
              row_q   <= '0;
              col_q   <= '0;
              busy_q  <= 1'b1;
            end
          end
          READ: state_q <= STREAM;
          STREAM: begin
            if (xfer) begin
              if (addr_q == LAST_ADDR) begin
                state_q   <= FINISH;
                busy_q    <= 1'b0;
                drained_q <= 1'b1;
              end else begin
                state_q <= READ;
                addr_q  <= addr_q + ADDR_W'(1);
                if (col_q == LAST_COL) begin
                  col_q <= '0;
                  row_q <= row_q + IDX_W'(1);
                end else begin
                  col_q <= col_q + IDX_W'(1);
                end
              end
            end
          end
          FINISH: state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  fmap_out_slice u_slice (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .flush_i (done_fall),
    .beat_i  (beat_in),
    .ready_i (m_if.m_ready),
    .valid_o (out_vld),
    .beat_o  (beat_out)
  );

  assign m_if.m_valid = out_vld;
  assign m_if.m_data  = beat_out.data;
  assign m_if.m_row   = beat_out.row;
  assign m_if.m_col   = beat_out.col;
  assign m_if.m_last  = beat_out.last;
  assign busy_o       = busy_q;
  assign drained_o    = drained_q;
  assign aborted_o    = aborted_q;
endmodule

// File: tb/tb_cnn_fmap_reader.sv
// Scoreboard bench for cnn_fmap_reader: expected beats are queued when a stream is started
// and popped on every observed handshake.
module tb_cnn_fmap_reader;
  import cnn_fmap_reader_pkg::*;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] ram [0:N_PIX-1];
  logic              eng_done;
  logic              busy;
  logic              drained;
  logic              aborted;

  cnn_fmap_reader_if m_if ();

  cnn_fmap_reader dut (
    .clk        (clk),
    .rst        (rst),
    .fmap_ram_i (ram),
    .eng_done_i (eng_done),
    .busy_o     (busy),
    .drained_o  (drained),
    .aborted_o  (aborted),
    .m_if       (m_if)
  );

  int n_checks = 0;
  int n_errors = 0;
  beat_t exp_q [$];

  int hs_cnt  = 0;
  int drn_cnt = 0;
  int abt_cnt = 0;
  int vld_cnt = 0;
  int ready_mode = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ready driver: 0 = always ready, 1 = repeating 1,0,0,1, 2 = never ready.
  initial begin
    int rcnt;
    rcnt = 0;
    m_if.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rcnt++;
      case (ready_mode)
        0:       m_if.m_ready = 1'b1;
        1:       m_if.m_ready = (rcnt % 4 == 0) || (rcnt % 4 == 3);
        default: m_if.m_ready = 1'b0;
      endcase
    end
  end

  // Monitor: scoreboard pops, hold-stability and pulse counting.
  initial begin
    logic  hold_pend;
    beat_t hold_beat;
    beat_t cur;
    beat_t e;
    hold_pend = 1'b0;
    hold_beat = '0;
    forever begin
      @(negedge clk);
      cur = '{data: m_if.m_data, row: m_if.m_row, col: m_if.m_col, last: m_if.m_last};
      if (rst) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          check("valid_held", {63'd0, m_if.m_valid || aborted}, 64'd1);
          if (m_if.m_valid) check("beat_held", 64'(cur), 64'(hold_beat));
        end
        if (m_if.m_valid) vld_cnt++;
        if (m_if.m_valid && m_if.m_ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 64'(cur), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", 64'(cur.data), 64'(e.data));
            check("beat_rowcol", {58'd0, cur.row, cur.col}, {58'd0, e.row, e.col});
            check("beat_last", {63'd0, cur.last}, {63'd0, e.last});
          end
        end
        hold_pend = m_if.m_valid && !m_if.m_ready;
        hold_beat = cur;
        if (drained) begin
          drn_cnt++;
          check("drain_q_empty", 64'(exp_q.size()), 64'd0);
        end
        if (aborted) abt_cnt++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_map(input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = ram[k];
      b.row  = IDX_W'(k / OUT_W);
      b.col  = IDX_W'(k % OUT_W);
      b.last = (k == N_PIX - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_drained(input int base);
    for (int i = 0; i < 400; i++) begin
      if (drn_cnt > base) break;
      tick();
    end
    check("drained_once", 64'(drn_cnt - base), 64'd1);
    check("busy_after_drain", {63'd0, busy}, 64'd0);
  endtask

  task automatic wait_beats(input int base, input int n);
    for (int i = 0; i < 400; i++) begin
      if (hs_cnt - base >= n) break;
      tick();
    end
    check("beats_reached", 64'(hs_cnt - base), 64'(n));
  endtask

  initial begin
    int base;
    int dbase;
    rst = 1'b1;
    eng_done = 1'b0;
    for (int k = 0; k < N_PIX; k++) ram[k] = DATA_W'(k - 10);
    repeat (3) tick();
    check("rst_outputs", {56'd0, busy, m_if.m_valid, m_if.m_last, drained, aborted, 3'd0}, 64'd0);
    check("rst_payload", {58'd0, m_if.m_row, m_if.m_col}, 64'd0);
    check("rst_data", 64'(m_if.m_data), 64'd0);
    rst = 1'b0;
    tick();

    // Full stream with ready held high; check first-beat latency.
    dbase = drn_cnt;
    push_map(N_PIX);
    eng_done = 1'b1;
    tick();
    check("lat_cycle1_valid", {63'd0, m_if.m_valid}, 64'd0);
    check("lat_cycle1_busy", {63'd0, busy}, 64'd1);
    tick();
    check("lat_cycle2_valid", {63'd0, m_if.m_valid}, 64'd1);
    wait_drained(dbase);

    // Level-high done must not restart; a fresh edge must.
    base = vld_cnt;
    repeat (10) tick();
    check("no_restart", 64'(vld_cnt - base), 64'd0);
    eng_done = 1'b0;
    repeat (2) tick();
    dbase = drn_cnt;
    push_map(N_PIX);
    eng_done = 1'b1;
    wait_drained(dbase);

    // Ready toggling 1,0,0,1.
    eng_done = 1'b0;
    repeat (2) tick();
    ready_mode = 1;
    dbase = drn_cnt;
    push_map(N_PIX);
    eng_done = 1'b1;
    wait_drained(dbase);
    ready_mode = 0;

    // Abort after beat 10.
    eng_done = 1'b0;
    repeat (2) tick();
    base = hs_cnt;
    push_map(11);
    eng_done = 1'b1;
    wait_beats(base, 11);
    tick();
    eng_done = 1'b0;
    tick();
    check("abort_valid", {63'd0, m_if.m_valid}, 64'd0);
    check("abort_pulse", {63'd0, aborted}, 64'd1);
    check("abort_busy", {63'd0, busy}, 64'd0);
    tick();
    check("abort_one_cycle", {63'd0, aborted}, 64'd0);
    check("abort_q_empty", 64'(exp_q.size()), 64'd0);
    dbase = drn_cnt;
    push_map(N_PIX);
    eng_done = 1'b1;
    wait_drained(dbase);

    // Reset with beat 20 valid and stalled.
    eng_done = 1'b0;
    repeat (2) tick();
    base = hs_cnt;
    push_map(20);
    eng_done = 1'b1;
    wait_beats(base, 20);
    ready_mode = 2;
    tick();
    tick();
    check("beat20_valid", {63'd0, m_if.m_valid}, 64'd1);
    check("beat20_data", 64'(m_if.m_data), 64'(ram[20]));
    check("beat20_rowcol", {58'd0, m_if.m_row, m_if.m_col}, {58'd0, 3'd3, 3'd2});
    rst = 1'b1;
    eng_done = 1'b0;
    tick();
    check("midrst_outputs", {56'd0, busy, m_if.m_valid, m_if.m_last, drained, aborted, 3'd0}, 64'd0);
    check("midrst_payload", {58'd0, m_if.m_row, m_if.m_col}, 64'd0);
    check("midrst_data", 64'(m_if.m_data), 64'd0);
    rst = 1'b0;
    ready_mode = 0;
    tick();
    check("midrst_q_empty", 64'(exp_q.size()), 64'd0);

    // Extreme values, random interior, toggling ready.
    ram[0] = 32'h8000_0000;
    ram[N_PIX-1] = 32'h7FFF_FFFF;
    for (int k = 1; k < N_PIX - 1; k++) ram[k] = $urandom;
    ready_mode = 1;
    dbase = drn_cnt;
    push_map(N_PIX);
    eng_done = 1'b1;
    wait_drained(dbase);
    ready_mode = 0;
    eng_done = 1'b0;
    repeat (3) tick();

    check("final_q_empty", 64'(exp_q.size()), 64'd0);
    check("abort_total", 64'(abt_cnt), 64'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
